imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Fetch controller and access arbiter for the 16K-word instruction memory. It owns the memory's 14-bit PC input and sequences instruction fetch into a registered IF stage with stall, branch-redirect and halt support. It also arbitrates the memory's write side between the program loader and fetch: the loader may write only while the core is idle. It sits between the instruction memory and the decode stage of the CPU.

## Interface
- ADDR_W, 14, PC/address width (memory depth 2^ADDR_W words)
- RESET_PC, 14'd0, PC loaded on reset and on IDLE→RUN
- NOP_WORD, 32'h0000_0000, instruction word injected on flush/halt/reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  IDLE→RUN (from RESET_PC); HALT→RUN (resume from held PC)
- halt  in  1  RUN→HALT request
- stall  in  1  hold PC and IF stage (RUN only)
- branch_taken  in  1  redirect fetch to branch_target
- branch_target  in  ADDR_W  redirect address
- imem_pc  out  ADDR_W  read address to instruction memory (= pc_q)
- imem_ir  in  32  combinational read data from memory
- if_ir  out  32  registered fetched instruction
- if_pc  out  ADDR_W  address of if_ir
- if_valid  out  1  if_ir is a real fetched instruction
- ld_req  in  1  loader write request
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  32  loader write data
- ld_gnt  out  1  loader write accepted this cycle (combinational)
- mem_we  out  1  memory write enable
- mem_waddr  out  ADDR_W  memory write address
- mem_wdata  out  32  memory write data
- running  out  1  state == RUN
- halted  out  1  state == HALT
- fetch_count  out  32  count of valid fetches since reset

## Operation
- States: IDLE (reset), RUN, HALT. 2-bit encoded state register.
- IDLE: ld_gnt = mem_we = ld_req; mem_waddr = ld_addr; mem_wdata = ld_data. If start && !ld_req: → RUN, pc_q ← RESET_PC. If start && ld_req: loader wins, start ignored, stay IDLE.
- RUN/HALT: ld_gnt = mem_we = 0, ld_req ignored (not queued). mem_waddr/mem_wdata still pass ld_addr/ld_data; the write strobe is mem_we only.
- RUN, per-cycle priority (highest first):
  - halt: → HALT; if_valid ← 0; if_ir ← NOP_WORD; pc_q ← branch_taken ? branch_target : pc_q.
  - branch_taken: pc_q ← branch_target; if_valid ← 0; if_ir ← NOP_WORD; if_pc ← pc_q. This is a one-bubble flush and overrides stall.
  - stall: pc_q, if_ir, if_pc, if_valid all hold.
  - else: if_ir ← imem_ir; if_pc ← pc_q; if_valid ← 1; pc_q ← pc_q + 1 mod 2^ADDR_W (16383→0); fetch_count ← fetch_count + 1.
- HALT: outputs hold (if_valid = 0). start → RUN and resumes from pc_q. halt/stall/branch are ignored in HALT.
- fetch_count increments only on cycles that load if_valid ← 1. It wraps at 2^32.
- rst overrides everything in any state, including mid-load and mid-run.

## Timing
- Reset values: pc_q/imem_pc = RESET_PC, if_ir = NOP_WORD, if_pc = 0, if_valid = 0, fetch_count = 0, running = 0, halted = 0, state = IDLE. ld_gnt/mem_we follow ld_req (IDLE).
- Fetch latency: instruction at address A appears on if_ir one cycle after imem_pc = A. Throughput is 1 word/cycle without stall.
- First valid fetch: start sampled at edge N; imem_pc = RESET_PC after N; if_valid = 1 after edge N+1.
- Branch: branch_taken at edge N gives a bubble after N. if_ir = mem[branch_target] with if_valid = 1 after N+1. The branch penalty is exactly 1 bubble.
- Loader write: zero-latency grant; the memory captures on the same edge that ld_gnt is high.
- running/halted are registered decodes of state and change on the same edge as the state.

## Test plan
- Reset, then load mem[0..2] via ld_req with data 0x11, 0x22, 0x33; pulse start → ld_gnt high for 3 cycles, mem_we only then. if_ir sequence after start is 0x11, 0x22, 0x33 with if_pc 0, 1, 2, and fetch_count = 3.
- RUN with stall high for 3 cycles at pc = 5 → imem_pc stays 5, if_ir/if_pc/if_valid frozen, fetch_count unchanged. Release → if_pc = 5 next.
- branch_taken with target 100 while stall is high at pc = 7 → one cycle if_valid = 0 with if_ir = NOP_WORD, then if_pc = 100, if_valid = 1.
- Wrap-around: branch to 16383, run 2 cycles → if_pc 16383 then 0.
- halt together with branch_taken (target 40) → halted = 1, if_valid = 0, imem_pc = 40. ld_req during HALT → ld_gnt = 0. start → if_pc = 40 next cycle after resume.
- rst asserted mid-RUN at pc = 9 → next cycle state IDLE, imem_pc = RESET_PC, if_ir = NOP_WORD, fetch_count = 0. start + ld_req same cycle → stays IDLE, write performed.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// Bus between the fetch controller, the instruction memory and the core/loader.
// master = core/loader/memory side, slave = imem_fetch_ctrl.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              start;
  logic              halt;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] imem_pc;
  logic [31:0]       imem_ir;
  logic [31:0]       if_ir;
  logic [ADDR_W-1:0] if_pc;
  logic              if_valid;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              running;
  logic              halted;
  logic [31:0]       fetch_count;

  modport master (
    output start, halt, stall, branch_taken, branch_target, imem_ir,
           ld_req, ld_addr, ld_data,
    input  imem_pc, if_ir, if_pc, if_valid, ld_gnt, mem_we, mem_waddr,
           mem_wdata, running, halted, fetch_count
  );

  modport slave (
    input  start, halt, stall, branch_taken, branch_target, imem_ir,
           ld_req, ld_addr, ld_data,
    output imem_pc, if_ir, if_pc, if_valid, ld_gnt, mem_we, mem_waddr,
           mem_wdata, running, halted, fetch_count
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer (IDLE/RUN/HALT) feeding a registered IF stage, plus
// loader/fetch write arbitration; 1-cycle fetch latency, stall holds, branch = 1 bubble.
module imem_fetch_ctrl #(
  parameter int                 ADDR_W   = 14,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]        NOP_WORD = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  imem_fetch_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_if_ir;
  logic [ADDR_W-1:0] r_if_pc;
  logic              r_if_valid;
  logic [31:0]       r_fetch_count;
  logic              r_running;
  logic              r_halted;
  logic              w_ld_gnt;
  logic              w_fetch;

  // State register; running/halted are decoded from the next state so they
  // flip on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_halted  <= (w_state_nxt == ST_HALT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start && !bus.ld_req) w_state_nxt = ST_RUN;
      ST_RUN:  if (bus.halt)                 w_state_nxt = ST_HALT;
      ST_HALT: if (bus.start)                w_state_nxt = ST_RUN;
      default:                               w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ld_gnt = 1'b0;
    w_fetch  = 1'b0;
    case (r_state)
      ST_IDLE: w_ld_gnt = bus.ld_req;
      ST_RUN:  w_fetch  = !bus.halt && !bus.branch_taken && !bus.stall;
      default: begin
        w_ld_gnt = 1'b0;
        w_fetch  = 1'b0;
      end
    endcase
  end

  // Fetch datapath: halt beats branch beats stall beats a normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_if_ir       <= NOP_WORD;
      r_if_pc       <= '0;
      r_if_valid    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.ld_req) r_pc <= RESET_PC;
        end
        ST_RUN: begin
          if (bus.halt) begin
            r_if_valid <= 1'b0;
            r_if_ir    <= NOP_WORD;
            if (bus.branch_taken) r_pc <= bus.branch_target;
          end else if (bus.branch_taken) begin
            r_pc       <= bus.branch_target;
            r_if_valid <= 1'b0;
            r_if_ir    <= NOP_WORD;
            r_if_pc    <= r_pc;
          end else if (w_fetch) begin
            r_if_ir       <= bus.imem_ir;
            r_if_pc       <= r_pc;
            r_if_valid    <= 1'b1;
            r_pc          <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_fetch_count <= r_fetch_count + 32'd1;
          end
        end
        default: begin
          r_pc <= r_pc;
        end
      endcase
    end
  end

  // Write side: address/data always pass through, only the strobe is gated.
  assign bus.ld_gnt      = w_ld_gnt;
  assign bus.mem_we      = w_ld_gnt;
  assign bus.mem_waddr   = bus.ld_addr;
  assign bus.mem_wdata   = bus.ld_data;

  assign bus.imem_pc     = r_pc;
  assign bus.if_ir       = r_if_ir;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_valid    = r_if_valid;
  assign bus.running     = r_running;
  assign bus.halted      = r_halted;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed test-plan sequence followed by random stimulus, checked against a
// transaction-level model of the fetch controller and a model of the memory.
module tb_imem_fetch_ctrl;
  localparam int DEPTH = 16384;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.ADDR_W(14)) bus ();

  imem_fetch_ctrl #(.ADDR_W(14), .RESET_PC(14'd0), .NOP_WORD(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Instruction memory: combinational read, write on the edge ld_gnt/mem_we is high.
  logic [31:0] mem [0:DEPTH-1];
  assign bus.imem_ir = mem[bus.imem_pc];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int          m_mode;     // 0 idle, 1 run, 2 halt
  int          m_pc;
  logic [31:0] m_ir;
  int          m_ifpc;
  logic        m_valid;
  logic [31:0] m_cnt;
  logic [31:0] m_mem [0:DEPTH-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit h, input bit st,
                            input bit b, input int tgt, input bit lr,
                            input int la, input logic [31:0] ld);
    if (m_mode == 0 && lr) m_mem[la] = ld;
    if (r) begin
      m_mode = 0; m_pc = 0; m_ir = NOP; m_ifpc = 0; m_valid = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (s && !lr) begin m_mode = 1; m_pc = 0; end
    end else if (m_mode == 1) begin
      if (h) begin
        m_mode = 2; m_valid = 0; m_ir = NOP;
        if (b) m_pc = tgt;
      end else if (b) begin
        m_ifpc = m_pc; m_pc = tgt; m_valid = 0; m_ir = NOP;
      end else if (!st) begin
        m_ir = m_mem[m_pc]; m_ifpc = m_pc; m_valid = 1;
        m_pc = (m_pc + 1) % DEPTH; m_cnt = m_cnt + 1;
      end
    end else begin
      if (s) m_mode = 1;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit h, input bit st,
                     input bit b, input int tgt, input bit lr,
                     input int la, input logic [31:0] ld);
    logic exp_gnt;
    @(negedge clk);
    rst               = r;
    bus.start         = s;
    bus.halt          = h;
    bus.stall         = st;
    bus.branch_taken  = b;
    bus.branch_target = tgt[13:0];
    bus.ld_req        = lr;
    bus.ld_addr       = la[13:0];
    bus.ld_data       = ld;
    #1;
    exp_gnt = (m_mode == 0) && lr;
    chk("ld_gnt", {31'b0, bus.ld_gnt}, {31'b0, exp_gnt});
    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_gnt});
    if (exp_gnt) begin
      chk("mem_waddr", {18'b0, bus.mem_waddr}, la);
      chk("mem_wdata", bus.mem_wdata, ld);
    end
    @(posedge clk);
    model_edge(r, s, h, st, b, tgt, lr, la, ld);
    #1;
    chk("imem_pc", {18'b0, bus.imem_pc}, m_pc);
    chk("if_ir", bus.if_ir, m_ir);
    chk("if_pc", {18'b0, bus.if_pc}, m_ifpc);
    chk("if_valid", {31'b0, bus.if_valid}, {31'b0, m_valid});
    chk("running", {31'b0, bus.running}, {31'b0, m_mode == 1});
    chk("halted", {31'b0, bus.halted}, {31'b0, m_mode == 2});
    chk("fetch_count", bus.fetch_count, m_cnt);
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]   = 32'hC0DE_0000 | i;
      m_mem[i] = 32'hC0DE_0000 | i;
    end
    m_mode = 0; m_pc = 0; m_ir = NOP; m_ifpc = 0; m_valid = 0; m_cnt = 0;
    rst = 1'b1;
    bus.start = 0; bus.halt = 0; bus.stall = 0; bus.branch_taken = 0;
    bus.branch_target = '0; bus.ld_req = 0; bus.ld_addr = '0; bus.ld_data = '0;

    // Reset, then load three words and start.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("reset_if_ir", bus.if_ir, NOP);
    chk("reset_count", bus.fetch_count, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 32'h11);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 32'h22);
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 32'h33);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("start_valid0", {31'b0, bus.if_valid}, 32'd0);
    idle_cyc();
    chk("first_ir", bus.if_ir, 32'h11);
    idle_cyc();
    chk("second_ir", bus.if_ir, 32'h22);
    idle_cyc();
    chk("third_ir", bus.if_ir, 32'h33);
    chk("third_pc", {18'b0, bus.if_pc}, 32'd2);
    chk("count3", bus.fetch_count, 32'd3);

    // Advance to pc 5, stall three cycles, release.
    idle_cyc();
    idle_cyc();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    chk("stall_pc", {18'b0, bus.imem_pc}, 32'd5);
    chk("stall_count", bus.fetch_count, 32'd5);
    idle_cyc();
    chk("release_pc", {18'b0, bus.if_pc}, 32'd5);

    // pc 7: branch to 100 with stall high.
    idle_cyc();
    cyc(0, 0, 0, 1, 1, 100, 0, 0, 32'h0);
    chk("bubble_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("bubble_ir", bus.if_ir, NOP);
    idle_cyc();
    chk("branch_pc", {18'b0, bus.if_pc}, 32'd100);

    // Wrap-around.
    cyc(0, 0, 0, 0, 1, 16383, 0, 0, 32'h0);
    idle_cyc();
    chk("wrap_pc_a", {18'b0, bus.if_pc}, 32'd16383);
    idle_cyc();
    chk("wrap_pc_b", {18'b0, bus.if_pc}, 32'd0);

    // Halt together with branch, loader during HALT, resume.
    cyc(0, 0, 1, 0, 1, 40, 0, 0, 32'h0);
    chk("halt_pc", {18'b0, bus.imem_pc}, 32'd40);
    chk("halted", {31'b0, bus.halted}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 32'hDEAD);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
    idle_cyc();
    chk("resume_pc", {18'b0, bus.if_pc}, 32'd40);

    // Reset mid-run at pc 9, then start + ld_req together.
    cyc(0, 0, 0, 0, 1, 9, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("rst_pc", {18'b0, bus.imem_pc}, 32'd0);
    chk("rst_count", bus.fetch_count, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 1, 3, 32'hABCD);
    chk("start_ld_idle", {31'b0, bus.running}, 32'd0);
    chk("ld_written", mem[3], 32'hABCD);

    // Random phase.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom % 60) == 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
          ($urandom % 4) == 0, ($urandom % 8) == 0, int'($urandom_range(0, DEPTH - 1)),
          ($urandom % 3) == 0, int'($urandom_range(0, DEPTH - 1)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
